// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA datapath blocks.
package rsa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefWidth = 256;
  localparam int unsigned DefMaxK  = 512;

  // Width needed to hold any shift count in 0..max_k.
  function automatic int unsigned calc_kw(input int unsigned max_k);
    return $clog2(max_k + 1);
  endfunction

endpackage

// File: rtl/mod_double_step.sv
// One modular doubling step: t <- 2t, minus n when the result is >= n.
module mod_double_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   t_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic             en_i,
  output logic [WIDTH:0]   t_o
);

  logic [WIDTH:0] dbl;

  // t_i < n_i, so the doubled value always fits in WIDTH+1 bits.
  always_comb begin
    dbl = t_i << 1;
    t_o = t_i;
    if (en_i) begin
      if (dbl >= {1'b0, n_i}) begin
        t_o = dbl - {1'b0, n_i};
      end else begin
        t_o = dbl;
      end
    end
  end

endmodule

// File: rtl/mont_preprocess.sv
// Montgomery-domain conversion: T = M * 2^K mod N by repeated modular doubling.
module mont_preprocess
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned MAX_K  = DefMaxK,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned KW     = calc_kw(MAX_K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] N_i,
  input  logic [WIDTH-1:0] M_i,
  input  logic [KW-1:0]    K_i,
  output logic             busy,
  output logic [WIDTH-1:0] T_o,
  output logic             finish,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH:0]   t_q, t_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] t_out_q, t_out_d;
  logic             err_flag_q, err_flag_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   stage_in  [UNROLL];
  logic [WIDTH:0]   stage_out [UNROLL];
  logic [UNROLL-1:0] step_en;
  logic [KW-1:0]    steps;
  logic             last_run;

  // Unrolled doubling chain; stages beyond the remaining count pass t through.
  for (genvar j = 0; j < UNROLL; j++) begin : g_step
    if (j == 0) begin : g_first
      assign stage_in[j] = t_q;
    end else begin : g_next
      assign stage_in[j] = stage_out[j-1];
    end
    assign step_en[j] = (32'(cnt_q) > j);
    mod_double_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .t_i (stage_in[j]),
      .n_i (n_q),
      .en_i(step_en[j]),
      .t_o (stage_out[j])
    );
  end

  assign steps    = (32'(cnt_q) >= UNROLL) ? KW'(UNROLL) : cnt_q;
  assign last_run = (32'(cnt_q) <= UNROLL);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    m_d        = m_q;
    k_d        = k_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    t_out_d    = t_out_q;
    err_flag_d = err_flag_q;
    // Outputs lag the state by one cycle so every output is a plain register.
    busy_d     = ((state_q == StCheck) || (state_q == StRun)) && !abort;
    finish_d   = (state_q == StDone);
    err_d      = (state_q == StDone) && err_flag_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = N_i;
          m_d     = M_i;
          k_d     = K_i;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else if ((n_q == '0) || (m_q >= n_q) || (32'(k_q) > MAX_K)) begin
          err_flag_d = 1'b1;
          t_out_d    = '0;
          state_d    = StDone;
        end else if (k_q == '0) begin
          err_flag_d = 1'b0;
          t_out_d    = m_q;
          state_d    = StDone;
        end else begin
          err_flag_d = 1'b0;
          t_d        = {1'b0, m_q};
          cnt_d      = k_q;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          t_d   = stage_out[UNROLL-1];
          cnt_d = cnt_q - steps;
          if (last_run) begin
            t_out_d = stage_out[UNROLL-1][WIDTH-1:0];
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      m_q        <= '0;
      k_q        <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      t_out_q    <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      m_q        <= m_d;
      k_q        <= k_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      t_out_q    <= t_out_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
    end
  end

  assign busy   = busy_q;
  assign T_o    = t_out_q;
  assign finish = finish_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mont_preprocess.sv
// Self-checking bench: two 8-bit engines (UNROLL 1 and 2) on shared inputs, one 256-bit engine.
module tb_mont_preprocess;

  localparam int unsigned MaxK8 = 20;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] n8, m8;
  logic [4:0] k8;
  logic a_busy, a_fin, a_err, b_busy, b_fin, b_err;
  logic [7:0] a_t, b_t;

  logic c_start, c_abort;
  logic [255:0] c_n, c_m, c_t;
  logic [9:0] c_k;
  logic c_busy, c_fin, c_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_preprocess #(.WIDTH(8), .MAX_K(MaxK8), .UNROLL(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .N_i(n8), .M_i(m8), .K_i(k8),
    .busy(a_busy), .T_o(a_t), .finish(a_fin), .err(a_err)
  );

  mont_preprocess #(.WIDTH(8), .MAX_K(MaxK8), .UNROLL(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .N_i(n8), .M_i(m8), .K_i(k8),
    .busy(b_busy), .T_o(b_t), .finish(b_fin), .err(b_err)
  );

  mont_preprocess #(.WIDTH(256), .MAX_K(512), .UNROLL(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .N_i(c_n), .M_i(c_m), .K_i(c_k),
    .busy(c_busy), .T_o(c_t), .finish(c_fin), .err(c_err)
  );

  typedef struct {
    logic [7:0] n;
    logic [7:0] m;
    logic [4:0] k;
    logic [7:0] t;
    logic       e;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: M * 2^K mod N straight from the definition.
  function automatic void model8(input logic [7:0] n, input logic [7:0] m, input logic [4:0] k,
                                 output logic [7:0] t, output logic e);
    longint x;
    e = (n == 0) || (m >= n) || (k > MaxK8);
    if (e) begin
      t = 8'd0;
    end else begin
      x = longint'(m) << k;
      t = 8'(x % longint'(n));
    end
  endfunction

  task automatic run8(input logic [7:0] n, input logic [7:0] m, input logic [4:0] k,
                      input logic [7:0] exp_t, input logic exp_e, input string tag);
    int lat_a, lat_b, busy_cnt;
    bit got_a, got_b;
    lat_a = (exp_e || k == 0) ? 2 : 2 + int'(k);
    lat_b = (exp_e || k == 0) ? 2 : 2 + (int'(k) + 1) / 2;
    @(posedge clk); #1;
    n8 = n; m8 = m; k8 = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands must be latched; scramble the pins.
    n8 = 8'($urandom); m8 = 8'($urandom); k8 = 5'($urandom);
    got_a = 0; got_b = 0; busy_cnt = 0;
    for (int c = 1; c <= 40 && !(got_a && got_b); c++) begin
      @(posedge clk); #1;
      if (!got_a && a_busy) busy_cnt++;
      if (a_fin && !got_a) begin
        got_a = 1;
        chk({tag, " lat_a"}, c, lat_a);
        chk({tag, " t_a"}, a_t, exp_t);
        chk({tag, " err_a"}, a_err, exp_e);
        chk({tag, " busy_at_fin_a"}, a_busy, 0);
        chk({tag, " busy_cycles_a"}, busy_cnt, lat_a - 1);
      end
      if (b_fin && !got_b) begin
        got_b = 1;
        chk({tag, " lat_b"}, c, lat_b);
        chk({tag, " t_b"}, b_t, exp_t);
        chk({tag, " err_b"}, b_err, exp_e);
      end
    end
    chk({tag, " timeout_a"}, got_a, 1);
    chk({tag, " timeout_b"}, got_b, 1);
    @(posedge clk); #1;
    chk({tag, " fin_pulse_a"}, a_fin, 0);
  endtask

  task automatic run256(input logic [255:0] n, input logic [255:0] m, input logic [9:0] k,
                        input logic [255:0] exp_t, input string tag);
    bit got;
    got = 0;
    @(posedge clk); #1;
    c_n = n; c_m = m; c_k = k; c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0; c_n = '0; c_m = '1;
    for (int c = 1; c <= 600 && !got; c++) begin
      @(posedge clk); #1;
      if (c_fin) begin
        got = 1;
        chk({tag, " lat"}, c, (k == 0) ? 2 : 2 + int'(k));
        chk({tag, " t"}, c_t, exp_t);
        chk({tag, " err"}, c_err, 0);
      end
    end
    chk({tag, " timeout"}, got, 1);
  endtask

  initial begin
    logic [7:0] rn, rm, rt;
    logic [4:0] rk;
    logic re;
    logic [255:0] wn, wm, wt;
    logic [767:0] wx;
    int fa, fb;
    bit seen;

    vecs[0] = '{n: 8'd13,  m: 8'd5,   k: 5'd8,  t: 8'd6,   e: 1'b0};
    vecs[1] = '{n: 8'd13,  m: 8'd5,   k: 5'd7,  t: 8'd3,   e: 1'b0};
    vecs[2] = '{n: 8'd13,  m: 8'd5,   k: 5'd0,  t: 8'd5,   e: 1'b0};
    vecs[3] = '{n: 8'd13,  m: 8'd13,  k: 5'd8,  t: 8'd0,   e: 1'b1};
    vecs[4] = '{n: 8'd0,   m: 8'd5,   k: 5'd8,  t: 8'd0,   e: 1'b1};
    vecs[5] = '{n: 8'd13,  m: 8'd5,   k: 5'd21, t: 8'd0,   e: 1'b1};
    vecs[6] = '{n: 8'd255, m: 8'd254, k: 5'd20, t: 8'd239, e: 1'b0};
    vecs[7] = '{n: 8'd8,   m: 8'd4,   k: 5'd1,  t: 8'd0,   e: 1'b0};
    vecs[8] = '{n: 8'd13,  m: 8'd12,  k: 5'd1,  t: 8'd11,  e: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; n8 = '0; m8 = '0; k8 = '0;
    c_start = 1'b0; c_abort = 1'b0; c_n = '0; c_m = '0; c_k = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", a_busy, 0);
    chk("reset finish", a_fin, 0);
    chk("reset err", a_err, 0);
    chk("reset t_a", a_t, 0);
    chk("reset t_c", c_t, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].n, vecs[i].m, vecs[i].k, vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rn = 8'($urandom_range(1, 255));
      rm = (i % 8 == 7) ? rn : 8'($urandom_range(0, int'(rn) - 1));
      rk = 5'($urandom_range(0, 22));
      model8(rn, rm, rk, rt, re);
      run8(rn, rm, rk, rt, re, $sformatf("rnd%0d", i));
    end

    // Abort mid-run: no finish, busy drops, result retained.
    run8(8'd13, 8'd5, 5'd8, 8'd6, 1'b0, "pre_abort");
    @(posedge clk); #1;
    n8 = 8'd13; m8 = 8'd7; k8 = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy_a", a_busy, 0);
    chk("abort busy_b", b_busy, 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (a_fin || b_fin) seen = 1;
    end
    chk("abort no_finish", seen, 0);
    chk("abort t_a kept", a_t, 6);
    chk("abort t_b kept", b_t, 6);
    run8(8'd13, 8'd5, 5'd8, 8'd6, 1'b0, "post_abort");

    // Start pulse during busy with other operands is ignored.
    @(posedge clk); #1;
    n8 = 8'd13; m8 = 8'd5; k8 = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n8 = 8'd11; m8 = 8'd1; k8 = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fa = 0; fb = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (a_fin) begin fa++; chk("busy_start t_a", a_t, 6); end
      if (b_fin) begin fb++; chk("busy_start t_b", b_t, 6); end
    end
    chk("busy_start count_a", fa, 1);
    chk("busy_start count_b", fb, 1);

    // Start held high: back-to-back operations, period ceil(K/U)+3.
    @(posedge clk); #1;
    n8 = 8'd13; m8 = 8'd5; k8 = 5'd3; start = 1'b1;
    fa = 0; fb = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (a_fin) begin fa++; chk("held t_a", a_t, 1); end
      if (b_fin) begin fb++; chk("held t_b", b_t, 1); end
    end
    start = 1'b0;
    chk("held count_a", fa, 5);
    chk("held count_b", fb, 6);
    repeat (12) @(posedge clk);

    // Reset mid-run clears all outputs.
    #1;
    n8 = 8'd13; m8 = 8'd5; k8 = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst busy_a", a_busy, 0);
    chk("rst fin_a", a_fin, 0);
    chk("rst err_a", a_err, 0);
    chk("rst t_a", a_t, 0);
    chk("rst t_b", b_t, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (a_fin || b_fin || a_busy) seen = 1;
    end
    chk("rst no_activity", seen, 0);

    // Full-width cases.
    wn = '0; wn[255] = 1'b1; wn[0] = 1'b1;
    wt = '0; wt[254:0] = '1;
    run256(wn, 256'd1, 10'd256, wt, "w256_a");
    run256('1, 256'd3, 10'd256, 256'd3, "w256_b");
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 8; w++) begin
        wn[w*32 +: 32] = $urandom;
        wm[w*32 +: 32] = $urandom;
      end
      wn[255] = 1'b1;
      wm = wm % wn;
      rk = 5'($urandom_range(1, 31));
      wx = {512'd0, wm} << rk;
      wt = 256'(wx % {512'd0, wn});
      run256(wn, wm, 10'(rk), wt, $sformatf("w256_rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_preprocess.md
Name: mont_preprocess

Overview:
Parametrised Montgomery pre-processing engine. It computes T = M·2^K mod N by K iterations of a modular doubling step: double, then subtract N if the result is ≥ N.
It sits ahead of the Montgomery multiplier in the RSA datapath and converts operands into the Montgomery domain. K = WIDTH gives M·R mod N. K = 2·WIDTH gives R² mod N when M = 1.
Compared with the single-width, fixed-count version, it adds a runtime shift count, multi-iteration-per-cycle unrolling, operand checking, abort, and a busy/finish handshake.

Parameters:
WIDTH, 256, operand width of N, M and T.
MAX_K, 512, largest accepted shift count K.
UNROLL, 1, doubling iterations per clock (1, 2 or 4).
KW, $clog2(MAX_K+1), derived width of K_i and of the iteration counter.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only while busy=0.
abort  in  1  synchronous cancel of an operation in progress.
N_i  in  WIDTH  modulus.
M_i  in  WIDTH  message; must satisfy M_i < N_i.
K_i  in  KW  shift count, 0..MAX_K.
busy  out  1  high from the cycle after start is accepted until finish.
T_o  out  WIDTH  result; valid while finish=1, held until the next accepted start.
finish  out  1  single-cycle completion pulse.
err  out  1  valid with finish; 1 means invalid operands.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, finish=0, err=0, T_o=0, counter=0, t=0. rst has priority over abort and start.
- States: IDLE, CHECK, RUN, DONE.
- IDLE:
  - start=1 captures N_i, M_i and K_i into registers; next state CHECK.
  - start=1 while busy is ignored (no re-capture).
- CHECK:
  - Error when N=0, or M≥N, or K>MAX_K: err=1, T_o=0, go to DONE.
  - When K=0: T_o=M, err=0, go to DONE.
  - Otherwise: t=M (WIDTH+1 bits), counter=K, go to RUN.
- RUN, per clock, for j in 1..min(UNROLL, counter):
  - t ← 2t;
  - if t ≥ N then t ← t − N;
  - then counter decreases by the number of iterations performed.
- RUN width rule: t < N holds before each step, so 2t < 2^(WIDTH+1) and WIDTH+1 bits suffice. The comparison is ≥, not >, so t = N reduces to 0.
- RUN exit: when counter reaches 0, T_o ← t[WIDTH-1:0] and go to DONE.
- DONE: finish=1 for exactly one cycle, busy=0 in that cycle, then IDLE. A start in the DONE cycle is ignored.
- Latency: finish is high exactly 2+ceil(K/UNROLL) cycles after the edge at which start was sampled. Error and K=0 cases take 2 cycles.
- abort=1 in CHECK or RUN: return to IDLE next edge, no finish pulse, T_o keeps its previous value, busy=0. abort in IDLE or DONE has no effect.
- Inputs N_i, M_i and K_i may change freely after capture without affecting the operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package rsa_pkg holds:
  - the state enum (IDLE, CHECK, RUN, DONE);
  - the default WIDTH=256 and MAX_K=512 constants;
  - the function clog2-based KW.
- One sub-module, mod_double_step (combinational, WIDTH+1 bit), performs one doubling with conditional subtract. It is instantiated UNROLL times in a chain; the last stage's output is masked by the remaining-count enable.

Test Plan:
- WIDTH=8, UNROLL=1: N=13, M=5, K=8, start -> T_o=6, err=0, finish exactly 10 cycles after start; busy high for 9 cycles before it.
- Same operands, UNROLL=2 -> T_o=6, finish 6 cycles after start; K=7 with UNROLL=2 -> T_o=3 (640 mod 13), finish 6 cycles after start.
- WIDTH=256, UNROLL=1: N=2^255+1, M=1, K=256 -> T_o=2^255−1 after 258 cycles. N=2^256−1, M=3, K=256 -> T_o=3.
- Boundaries, each finishing 2 cycles after start:
  - K=0, M=5, N=13 -> T_o=5, err=0;
  - M=13, N=13 -> err=1, T_o=0;
  - N=0 -> err=1;
  - K=MAX_K+1 -> err=1.
- abort asserted on cycle 4 of a K=8 run -> no finish, busy falls next cycle, T_o retains the prior result. An immediately following start with N=13, M=5, K=8 -> T_o=6.
- start held high continuously -> back-to-back operations, each re-captured in IDLE only. rst pulsed mid-RUN -> all outputs 0 the next cycle; start pulses during busy are ignored.
